multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle FSM and its datapath.
// The master drives strobes and selects; the slave supplies Opcode and MemReady.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic       MemReady;
  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       PCWrite;
  logic       Branch;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  Opcode, MemReady,
    output IorD, IRWrite, MemWrite, PCWrite, Branch,
    output RegDst, MemtoReg, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp, PCSrc,
    output Illegal, State
  );

  modport slave (
    output Opcode, MemReady,
    input  IorD, IRWrite, MemWrite, PCWrite, Branch,
    input  RegDst, MemtoReg, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp, PCSrc,
    input  Illegal, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main control FSM.
// Registered Moore outputs; fetch strobes are gated by MemReady.
module multicycle_control (
  input logic                  CLK,
  input logic                  RST_N,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       branch;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       fetch;
    logic       pcw;
  } ctl_t;

  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alusrcb = 2'b01;
        c.fetch   = 1'b1;
      end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      MEMREAD: c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWRITE: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b01;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      ADDIEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JUMP: begin
        c.pcsrc = 2'b10;
        c.pcw   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_q;
  state_t nxt;
  ctl_t   ctl_q;
  logic   ill_q;
  logic   lw, sw, rt, beq, addi, jmp, legal;

  always_comb begin
    lw    = bus.Opcode == OP_LW;
    sw    = bus.Opcode == OP_SW;
    rt    = bus.Opcode == OP_RT;
    beq   = bus.Opcode == OP_BEQ;
    addi  = bus.Opcode == OP_ADDI;
    jmp   = bus.Opcode == OP_J;
    legal = lw | sw | rt | beq | addi | jmp;
  end

  always_comb begin
    nxt = FETCH;
    case (state_q)
      FETCH:    nxt = bus.MemReady ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          lw, sw:  nxt = MEMADR;
          rt:      nxt = EXECUTE;
          beq:     nxt = BRANCH;
          addi:    nxt = ADDIEXEC;
          jmp:     nxt = JUMP;
          default: nxt = FETCH;
        endcase
      end
      MEMADR: begin
        unique case (1'b1)
          lw:      nxt = MEMREAD;
          sw:      nxt = MEMWRITE;
          default: nxt = FETCH;
        endcase
      end
      MEMREAD:  nxt = bus.MemReady ? MEMWB : MEMREAD;
      MEMWRITE: nxt = bus.MemReady ? FETCH : MEMWRITE;
      EXECUTE:  nxt = ALUWB;
      ADDIEXEC: nxt = ADDIWB;
      default:  nxt = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= FETCH;
      ctl_q   <= ctl_of(FETCH);
      ill_q   <= 1'b0;
    end else begin
      state_q <= nxt;
      ctl_q   <= ctl_of(nxt);
      if (state_q == DECODE && !legal)
        ill_q <= 1'b1;
    end
  end

  // Fetch strobes follow MemReady within the cycle and die with reset.
  assign bus.IRWrite  = ctl_q.fetch & bus.MemReady & RST_N;
  assign bus.PCWrite  = ((ctl_q.fetch & bus.MemReady) | ctl_q.pcw) & RST_N;
  assign bus.IorD     = ctl_q.iord;
  assign bus.MemWrite = ctl_q.memwrite;
  assign bus.Branch   = ctl_q.branch;
  assign bus.RegDst   = ctl_q.regdst;
  assign bus.MemtoReg = ctl_q.memtoreg;
  assign bus.RegWrite = ctl_q.regwrite;
  assign bus.ALUSrcA  = ctl_q.alusrca;
  assign bus.ALUSrcB  = ctl_q.alusrcb;
  assign bus.ALUOp    = ctl_q.aluop;
  assign bus.PCSrc    = ctl_q.pcsrc;
  assign bus.Illegal  = ill_q;
  assign bus.State    = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control.
// Expected state paths are derived per instruction class.
module tb_multicycle_control;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  typedef int iq_t[$];

  logic CLK = 1'b0;
  logic RST_N;
  int   n_chk = 0;
  int   n_ok = 0;
  bit   ill_m = 1'b0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_ok++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == LW || op == SW || op == RT ||
           op == BEQ || op == ADDI || op == JMP;
  endfunction

  function automatic iq_t path(input logic [5:0] op);
    iq_t q;
    case (op)
      LW:      q = '{0, 1, 2, 3, 4};
      SW:      q = '{0, 1, 2, 5};
      RT:      q = '{0, 1, 6, 7};
      BEQ:     q = '{0, 1, 8};
      ADDI:    q = '{0, 1, 9, 10};
      JMP:     q = '{0, 1, 11};
      default: q = '{0, 1};
    endcase
    return q;
  endfunction

  // {IorD,MemWrite,Branch,RegDst,MemtoReg,RegWrite,ALUSrcA,
  //  ALUSrcB,ALUOp,PCSrc,IRWrite,PCWrite}
  function automatic logic [14:0] exp_out(input int st, input bit rdy);
    logic iord, mw, br, rd, m2r, rw, sa, irw, pcw;
    logic [1:0] sb, aop, pc;
    {iord, mw, br, rd, m2r, rw, sa, irw, pcw} = '0;
    {sb, aop, pc} = '0;
    case (st)
      0: begin sb = 2'd1; irw = rdy; pcw = rdy; end
      1: sb = 2'd3;
      2: begin sa = 1; sb = 2'd2; end
      3: iord = 1;
      4: begin m2r = 1; rw = 1; end
      5: begin iord = 1; mw = 1; end
      6: begin sa = 1; aop = 2'd2; end
      7: begin rd = 1; rw = 1; end
      8: begin sa = 1; aop = 2'd1; pc = 2'd1; br = 1; end
      9: begin sa = 1; sb = 2'd2; end
      10: rw = 1;
      11: begin pc = 2'd2; pcw = 1; end
      default: ;
    endcase
    return {iord, mw, br, rd, m2r, rw, sa, sb, aop, pc, irw, pcw};
  endfunction

  function automatic logic [14:0] obs_out();
    return {bus.IorD, bus.MemWrite, bus.Branch, bus.RegDst,
            bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUOp, bus.PCSrc, bus.IRWrite, bus.PCWrite};
  endfunction

  // Entered and left at posedge+1. hold<0: random MemReady,
  // else MemReady low for the first hold cycles of each wait state.
  task automatic run_instr(input logic [5:0] op, input int hold,
                           input int abort_st);
    iq_t seq;
    int  rwn;
    bit  want_rw;
    seq = path(op);
    rwn = 0;
    want_rw = (op == LW) || (op == RT) || (op == ADDI);
    foreach (seq[k]) begin
      bit stay;
      int dwell;
      dwell = 0;
      do begin
        bit rdy;
        rdy = (hold < 0) ? ($urandom_range(0, 3) != 0) : (dwell >= hold);
        bus.MemReady = rdy;
        bus.Opcode = (seq[k] == 1 || seq[k] == 2) ? op : 6'($urandom);
        #3;
        chk("state", 32'(bus.State), seq[k]);
        chk("outs", 32'(obs_out()), 32'(exp_out(seq[k], rdy)));
        chk("illegal", 32'(bus.Illegal), 32'(ill_m));
        rwn += int'(bus.RegWrite);
        if (seq[k] == abort_st) begin
          RST_N = 1'b0;
          bus.MemReady = 1'b1;
          #1;
          chk("rst_state", 32'(bus.State), 0);
          chk("rst_regwrite", 32'(bus.RegWrite), 0);
          chk("rst_illegal", 32'(bus.Illegal), 0);
          chk("rst_strobes",
              32'({bus.IRWrite, bus.PCWrite, bus.MemWrite}), 0);
          ill_m = 1'b0;
          @(posedge CLK);
          #1;
          RST_N = 1'b1;
          return;
        end
        stay = (seq[k] == 0 || seq[k] == 3 || seq[k] == 5) && !rdy;
        if (seq[k] == 1 && !is_legal(op)) ill_m = 1'b1;
        dwell++;
        @(posedge CLK);
        #1;
      end while (stay);
    end
    chk("regwrite_cnt", rwn, want_rw ? 1 : 0);
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    RST_N = 1'b0;
    bus.MemReady = 1'b1;
    bus.Opcode = LW;
    #4;
    chk("reset_state", 32'(bus.State), 0);
    chk("reset_illegal", 32'(bus.Illegal), 0);
    @(posedge CLK);
    #1;
    chk("reset_strobes",
        32'({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite}), 0);
    chk("reset_hold", 32'(bus.State), 0);
    RST_N = 1'b1;

    run_instr(LW, 0, -1);
    run_instr(SW, 2, -1);
    run_instr(RT, 0, -1);
    run_instr(ADDI, 0, -1);
    run_instr(BEQ, 0, -1);
    run_instr(JMP, 0, -1);
    run_instr(JMP, 3, -1);
    run_instr(6'b111111, 0, -1);
    run_instr(LW, 0, -1);
    run_instr(6'b110000, -1, -1);
    run_instr(LW, 0, 4);
    run_instr(LW, 1, -1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, -1, -1);
    end

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
